// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multi-cycle sequencer for the EX-stage shift unit. One request at a time
// (SLL / SRL / SRA, op 11 passes the operand through) is processed by walking
// a single log-shifter stage per cycle over the five shift-amount bits.
// While an operation is in flight, busy/stall hold the pipeline. The result
// is presented with a one-cycle done pulse.
//
// Optional feature (compile-time macro SHIFT_EARLY_EXIT_EN):
//   defined   - SHIFT leaves as soon as no higher shift-amount bit is set
//               (op 11 leaves after the first SHIFT cycle).
//   undefined - fixed latency: five SHIFT cycles for every request.
//   Results are identical either way; only the latency changes.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only in IDLE
//   op     in   2      00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   A      in   WIDTH  operand to shift
//   B      in   WIDTH  shift amount, only B[SHW-1:0] is used
//   flush  in   1      abort the current operation
//   busy   out  1      high while not in IDLE
//   stall  out  1      busy | (start & ~flush), combinational
//   done   out  1      one-cycle completion pulse, O valid
//   O      out  WIDTH  result, held until the next completion
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] O
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] K_LAST = 3'(SHW - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic [SHW-1:0]   r_sh;
  logic [2:0]       r_k;
  logic [WIDTH-1:0] r_O;

  logic             w_accept;
  logic             w_last_stage;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_acc_stage;
  logic             w_unused_b;

  // Upper shift-amount bits are architecturally ignored (modulo WIDTH).
  assign w_unused_b = ^B[WIDTH-1:SHW];

  // One log-shifter stage: shift by amt with the fill rule of the opcode.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] acc,
    input logic [1:0]       sop,
    input logic [SHW-1:0]   amt
  );
    logic [WIDTH-1:0] res;
    case (sop)
      2'b00:   res = acc << amt;
      2'b01:   res = acc >> amt;
      2'b10:   res = $unsigned($signed(acc) >>> amt);
      default: res = acc;
    endcase
    return res;
  endfunction

  assign w_accept = start & ~flush;

  // Stage k shifts by 2^k, applied only when the matching amount bit is set.
  assign w_amt       = SHW'(1) << r_k;
  assign w_acc_stage = r_sh[r_k] ? shift_stage(r_acc, r_op, w_amt) : r_acc;

`ifdef SHIFT_EARLY_EXIT_EN
  // Remaining stages are no-ops once every higher amount bit is clear.
  assign w_last_stage = (r_k == K_LAST) || (r_op == 2'b11) ||
                        (((r_sh >> r_k) >> 1) == '0);
`else
  assign w_last_stage = (r_k == K_LAST);
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (w_last_stage) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, per-stage accumulator update and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_op  <= 2'b00;
      r_sh  <= '0;
      r_k   <= 3'd0;
      r_O   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= A;
            r_op  <= op;
            r_sh  <= B[SHW-1:0];
            r_k   <= 3'd0;
          end
        end
        SHIFT: begin
          if (!flush) begin
            r_acc <= w_acc_stage;
            r_k   <= r_k + 3'd1;
          end
        end
        DONE: begin
          if (!flush) begin
            r_O <= r_acc;
          end
        end
        default: begin
          r_k <= 3'd0;
        end
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign stall = busy | w_accept;
  assign done  = (r_state == DONE) & ~flush;

  // The result must already be visible in the done cycle, while r_O is only
  // committed at the end of it (so a flush in DONE leaves O untouched).
  assign O = done ? r_acc : r_O;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Directed bench for shift_seq_ctrl. A transaction-level model (result from
// plain shift arithmetic, busy as a countdown of the expected latency) is
// compared to the DUT on every falling edge; hand-computed results and
// done-cycle numbers pin the model for the directed cases.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] O;

  int n_vec = 0;
  int n_err = 0;

`ifdef SHIFT_EARLY_EXIT_EN
  localparam int L2 = 2;
  localparam int L3 = 3;
  localparam int L4 = 4;
  localparam int L5 = 5;
`else
  localparam int L2 = 6;
  localparam int L3 = 6;
  localparam int L4 = 6;
  localparam int L5 = 6;
`endif

  shift_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .O     (O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned s;
    logic signed [31:0] sa;
    s  = b % 32;
    sa = a;
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'(sa >>> s);
      default: return a;
    endcase
  endfunction

  // Cycle (counting the start-sampling edge as end of cycle 0) that shows done.
  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef SHIFT_EARLY_EXIT_EN
    int unsigned s;
    s = b % 32;
    if (o == 2'b11) return 2;
    for (int k = 4; k >= 0; k--) begin
      if (((s >> k) & 1) == 1) return k + 2;
    end
    return 2;
`else
    return 6;
`endif
  endfunction

  int          m_cnt = 0;   // cycles of busy still to come (incl. current)
  logic [31:0] m_res = '0;
  logic [31:0] m_O   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_O   = '0;
    end else if (m_cnt == 0) begin
      if (start && !flush) begin
        m_res = ref_result(op, A, B);
        m_cnt = ref_latency(op, B);
      end
    end else if (flush) begin
      m_cnt = 0;
    end else begin
      if (m_cnt == 1) m_O = m_res;
      m_cnt--;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic e_busy, e_done;
    logic [31:0] e_O;
    e_busy = (m_cnt != 0);
    e_done = (m_cnt == 1) && !flush;
    e_O    = e_done ? m_res : m_O;
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
    chk("stall", 32'(stall), 32'(e_busy | (start & ~flush)));
    chk("O",     O,          e_O);
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
  endtask

  // Called at the start of cycle c0; waits (bounded) for done.
  task automatic wait_done(input int c0, input int exp_cyc, input logic [31:0] exp_o,
                           input string name);
    int cyc;
    bit found;
    cyc   = c0;
    found = 1'b0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({name, "_result"}, O, exp_o);
  endtask

  // Called at the start of cycle 0; returns at the start of the cycle after done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_o, input int exp_cyc, input string name);
    issue(o, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, exp_cyc, exp_o, name);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; A = '0; B = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_O", O, 32'h0);
    start = 1'b1; #1;
    chk("rst_stall_follows_start", 32'(stall), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(2'b00, 32'h00000001, 32'd31, 32'h80000000, 6,  "sll31");
    do_op(2'b10, 32'h80000000, 32'd4,  32'hF8000000, L4, "sra4");
    do_op(2'b01, 32'h80000000, 32'd4,  32'h08000000, L4, "srl4");
    do_op(2'b00, 32'h0000000F, 32'h21, 32'h0000001E, L2, "sll_mod32");
    do_op(2'b11, 32'h12345678, 32'd7,  32'h12345678, L2, "op11");

    // Second start while busy is dropped.
    issue(2'b01, 32'hFFFF0000, 32'd8);
    @(posedge clk); #1; start = 1'b0;             // cycle 1
    @(posedge clk); #1;                           // cycle 2
    @(posedge clk); #1; issue(2'b00, 32'hDEADBEEF, 32'd1); // cycle 3
    @(posedge clk); #1; start = 1'b0;             // cycle 4
    wait_done(4, L5, 32'h00FFFF00, "ignore_2nd");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("O_held", O, 32'h00FFFF00);

    // Flush in cycle 3 aborts; O keeps its old value; cycle-4 start accepted.
    issue(2'b00, 32'h00000001, 32'd5);
    @(posedge clk); #1; start = 1'b0;             // cycle 1
    @(posedge clk); #1;                           // cycle 2
    @(posedge clk); #1; flush = 1'b1;             // cycle 3
    @(posedge clk); #1; flush = 1'b0;             // cycle 4
    chk("flush_busy_low", 32'(busy), 32'd0);
    chk("flush_O_kept", O, 32'h00FFFF00);
    do_op(2'b00, 32'h00000003, 32'd2, 32'h0000000C, L3, "after_flush");

    // start together with flush in IDLE is ignored.
    issue(2'b01, 32'h00000100, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-SHIFT.
    issue(2'b00, 32'h00000001, 32'd3);
    @(posedge clk); #1; start = 1'b0;             // cycle 1
    @(posedge clk); #2;                           // cycle 2, between edges
    rst = 1'b1; #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_O", O, 32'h0);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(2'b01, 32'h000000F0, 32'd4, 32'h0000000F, L4, "after_rst");

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle sequencer for the EX-stage shift unit of the pipelined CPU. It accepts one shift request at a time (SLL/SRL/SRA) and walks a single log-shifter stage per cycle over the five shift-amount bits. It drives `busy`/`stall` to the hazard unit so the pipeline holds while the shift is in progress. It presents the result with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; fixed at 32 for this design.
- `SHW`, 5: shift-amount bits used (log2 WIDTH).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
- `A`  in  32  operand to shift.
- `B`  in  32  shift amount; only `B[4:0]` is used and upper bits are ignored.
- `flush`  in  1  abort the current operation (pipeline flush).
- `busy`  out  1  high while not in IDLE.
- `stall`  out  1  `busy | (start & ~flush)`; combinational, to the hazard unit.
- `done`  out  1  one-cycle pulse; `O` is valid.
- `O`  out  32  result register; holds its value until the next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start & ~flush`, latch `A` into `acc`, `op` into `op_r`, `B[4:0]` into `sh_r`; clear `k` to 0; go to SHIFT.
  - `start` with `flush` is ignored.
- **SHIFT**, one stage per cycle:
  - If `sh_r[k]`, shift `acc` by 2^k.
  - SLL zero-fills from the LSB.
  - SRL zero-fills from the MSB.
  - SRA fills with `acc[31]`; the sign is preserved stage to stage.
  - op 11: `acc` is unchanged regardless of `sh_r`.
  - Increment `k`. After the stage with `k==4`, go to DONE.
- **DONE**: load `O <= acc`, assert `done` for this cycle, return to IDLE.
- `start` while `busy` is ignored and not queued. The requester must hold `start` until it sees `done`; `stall` keeps the pipeline frozen.
- `flush` in SHIFT or DONE:
  - Go to IDLE at the next edge.
  - `done` is not asserted in that DONE cycle if `flush` is high.
  - `O` keeps its old value.
- Shift amount is modulo 32 (`B = 0x21` shifts by 1).

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `O` 0x00000000, `acc` 0, `k` 0. `stall` follows `start` combinationally.
- `rst` mid-operation returns to IDLE immediately (asynchronous). No `done` is produced.
- Latency, start sampled at edge of cycle 0:
  - SHIFT occupies cycles 1–5.
  - `done` and valid `O` appear in cycle 6.
  - The earliest next `start` is accepted in cycle 7.
- Throughput: one operation per 7 cycles (full sequence).
- `busy` is high in cycles 1–6.

## Configuration
- Macro: `SHIFT_EARLY_EXIT_EN`.
- Defined:
  - In SHIFT, after applying stage k, if `sh_r[4:k+1] == 0` (or k==4), go to DONE.
  - op 11 always exits after the first SHIFT cycle.
  - Shift by 0 or 1 gives `done` in cycle 2. Shift by 4 gives `done` in cycle 4. Shifts of 16–31 still take the full 6 cycles.
- Undefined: fixed 6-cycle latency for every request. Results are identical either way.

## Test plan
- SLL `A=0x00000001`, `B=31` -> `O=0x80000000`, `done` in cycle 6, `busy` high cycles 1–6, `O=0` before that.
- SRA `A=0x80000000`, `B=4` -> `0xF8000000`. SRL with the same operands -> `0x08000000`. Both give cycle 6 without the macro and cycle 4 with it.
- SLL `A=0x0000000F`, `B=0x00000021` -> `0x0000001E` (modulo 32). op 11, `A=0x12345678`, `B=7` -> `0x12345678`.
- `start` with `A=0xFFFF0000`, SRL, `B=8`; pulse `start` again with new operands in cycle 3. The second request is ignored; the first yields `0x00FFFF00`.
- `flush` in cycle 3 of SLL `A=1`, `B=5` -> no `done`, `O` retains its previous value, `busy` low in cycle 4, and a new start in cycle 4 is accepted.
- Assert `rst` asynchronously mid-SHIFT -> `busy` 0 and `O` 0 immediately, no `done`. After release, a request completes normally.
